// File: rtl/word_serializer_if.sv
// word_serializer_if
//   Handshake and serial-output bundle for word_serializer.
//   slave  : serializer side (takes words, drives the serial stream)
//   master : producer/consumer side (offers words, strobes out_en)
//   Signals: in_valid/in_ready/in_data (word handshake),
//            out_en (consumer advance), out_valid/out_bit/out_first/
//            out_last (serial frame), busy (frame in progress).
interface word_serializer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_en;
   logic             out_valid;
   logic             out_bit;
   logic             out_first;
   logic             out_last;
   logic             busy;

   modport slave (
      input  in_valid, in_data, out_en,
      output in_ready, out_valid, out_bit, out_first, out_last, busy
   );

   modport master (
      output in_valid, in_data, out_en,
      input  in_ready, out_valid, out_bit, out_first, out_last, busy
   );
endinterface

// File: rtl/word_serializer.sv
// word_serializer
//   Parallel-to-serial converter. Takes a WIDTH-bit word on a valid/ready
//   handshake and emits it LSB first, one bit per out_en strobe, with
//   first/last frame markers. A new word can be accepted on the edge that
//   consumes the last bit, so back-to-back words stream without a gap.
//
//   Optional feature: define WORD_SERIALIZER_PARITY_EN to append an
//   even-parity bit (XOR of the accepted word) after the data bits; out_last
//   then marks the parity bit.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset
//     bus  - word_serializer_if.slave (handshake + serial outputs)
module word_serializer #(
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   word_serializer_if.slave bus
);

`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             shifting;
   logic             last;
   logic             in_rdy;
   logic             accept;
   logic             bit_sel;

   assign shifting = (state == S_SHIFT);
   assign last     = shifting && (cnt == CNT_LAST);

   // Ready in IDLE, or on the edge that consumes the last bit so the next
   // word slots in without an idle bubble. Held low during reset so a
   // producer never sees a handshake that reset would discard.
   assign in_rdy = !rst && (!shifting || (last && bus.out_en));
   assign accept = bus.in_valid && in_rdy;

`ifdef WORD_SERIALIZER_PARITY_EN
   logic par_q;

   // Parity is captured with the word; by the time it is emitted the shift
   // register has been fully drained.
   always_ff @(posedge clk) begin
      if (rst)         par_q <= 1'b0;
      else if (accept) par_q <= ^bus.in_data;
   end

   assign bit_sel = (cnt == CW'(WIDTH)) ? par_q : sreg[0];
`else
   assign bit_sel = sreg[0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         sreg  <= '0;
         cnt   <= '0;
      end else if (accept) begin
         state <= S_SHIFT;
         sreg  <= bus.in_data;
         cnt   <= '0;
      end else if (shifting && bus.out_en) begin
         sreg <= {1'b0, sreg[WIDTH-1:1]};
         if (last) begin
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = shifting;
   assign bus.busy      = shifting;
   assign bus.out_bit   = shifting && bit_sel;
   assign bus.out_first = shifting && (cnt == '0);
   assign bus.out_last  = last;

endmodule

// File: tb/tb_word_serializer.sv
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errs;

   word_serializer_if #(.WIDTH(8)) bus ();

   word_serializer #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs after the falling edge, let comb settle.
   task automatic cyc(input logic v, input logic [7:0] d, input logic e);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.out_en   = e;
      #1;
   endtask

   function automatic logic exp_bit(input logic [7:0] w, input int i);
      if (i < 8) return w[i];
      return ^w;
   endfunction

   task automatic check_bit(input string tag, input logic [7:0] w, input int i, input logic e);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".busy"},  32'(bus.busy),      32'd1);
      chk({tag, ".bit"},   32'(bus.out_bit),   32'(exp_bit(w, i)));
      chk({tag, ".first"}, 32'(bus.out_first), 32'(i == 0));
      chk({tag, ".last"},  32'(bus.out_last),  32'(i == FRAME - 1));
      chk({tag, ".ready"}, 32'(bus.in_ready),  32'((i == FRAME - 1) && e));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".busy"},  32'(bus.busy),      32'd0);
      chk({tag, ".bit"},   32'(bus.out_bit),   32'd0);
      chk({tag, ".first"}, 32'(bus.out_first), 32'd0);
      chk({tag, ".last"},  32'(bus.out_last),  32'd0);
      chk({tag, ".ready"}, 32'(bus.in_ready),  32'd1);
   endtask

   task automatic accept(input string tag, input logic [7:0] w);
      cyc(1'b1, w, 1'b0);
      chk({tag, ".acc_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   // Full frame with out_en held high; in_data changed to junk mid-frame.
   task automatic run_frame(input string tag, input logic [7:0] w, input logic [7:0] junk);
      for (int i = 0; i < FRAME; i++) begin
         cyc(1'b0, junk, 1'b1);
         check_bit(tag, w, i, 1'b1);
      end
   endtask

   logic [3:0] stall_pat;
   int         bi;
   int         n;

   initial begin
      checks       = 0;
      errs         = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.out_en   = 1'b0;

      // Reset for two edges; ready forced low while rst is high.
      @(negedge clk);
      bus.in_valid = 1'b1;
      #1;
      chk("rst.valid", 32'(bus.out_valid), 32'd0);
      chk("rst.ready", 32'(bus.in_ready),  32'd0);
      @(negedge clk);
      #1;
      chk("rst2.valid", 32'(bus.out_valid), 32'd0);
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("post_rst");

      // Single word A5: 1,0,1,0,0,1,0,1 (+ parity 0).
      accept("a5", 8'hA5);
      run_frame("a5", 8'hA5, 8'hA5);
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("a5_end");

      // Stall: 0F with out_en pattern 1,0,0,1 repeating.
      stall_pat = 4'b1001;
      accept("stall", 8'h0F);
      bi = 0;
      n  = 0;
      while (bi < FRAME && n < 60) begin
         cyc(1'b0, 8'h00, stall_pat[3 - (n % 4)]);
         check_bit("stall", 8'h0F, bi, bus.out_en);
         if (bus.out_en) bi++;
         n++;
      end
      chk("stall.bound", 32'(bi), 32'(FRAME));
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("stall_end");

      // Back-to-back: 01 then 80, in_valid held high, no gap.
      accept("b2b", 8'h01);
      for (int i = 0; i < FRAME; i++) begin
         cyc(1'b1, 8'h80, 1'b1);
         check_bit("b2b0", 8'h01, i, 1'b1);
      end
      run_frame("b2b1", 8'h80, 8'h00);
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("b2b_end");

      // Input stability: 3C held despite in_data = FF mid-frame.
      accept("stab", 8'h3C);
      run_frame("stab", 8'h3C, 8'hFF);
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("stab_end");

      // Reset mid-frame after 3 bits, with a competing accept and out_en.
      accept("rmid", 8'hFF);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         check_bit("rmid", 8'hFF, i, 1'b1);
      end
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h55;
      bus.out_en   = 1'b1;
      #1;
      chk("rmid.rst_ready", 32'(bus.in_ready), 32'd0);
      cyc(1'b0, 8'h00, 1'b1);
      check_idle("rmid_after");
      accept("r02", 8'h02);
      run_frame("r02", 8'h02, 8'h00);
      cyc(1'b0, 8'h00, 1'b0);
      check_idle("r02_end");

      // out_en ignored in IDLE.
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 8'hFF, 1'b1);
         check_idle("idle_en");
      end
      accept("post_idle", 8'hA5);
      run_frame("post_idle", 8'hA5, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial converter for the bit-serial datapath. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enabled cycle, LSB first, with frame markers. It is the transmit end of the shift-register deserializer: a downstream deserializer clocked by the same `out_en` reassembles the word in order, bit 0 first.

## Interface
- `WIDTH`, default 8: data word width; must be ≥ 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  serializer will take `in_data` at this edge.
- `in_data`  in  WIDTH  parallel word.
- `out_en`  in  1  consumer advance strobe; the current bit is consumed at this edge.
- `out_valid`  out  1  `out_bit` holds a frame bit.
- `out_bit`  out  1  current serial bit.
- `out_first`  out  1  current bit is the first bit of the frame.
- `out_last`  out  1  current bit is the last bit of the frame.
- `busy`  out  1  a frame is in progress; equals `out_valid`.

## Operation
- Two states:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being emitted.
- The block holds a WIDTH-bit shift register `sreg` and a bit counter `cnt` of width $clog2(FRAME+1).
  - FRAME = WIDTH, or WIDTH+1 with parity enabled.
- Accept occurs when `in_valid && in_ready` at a rising edge:
  - `sreg` ← `in_data`.
  - `cnt` ← 0.
  - State ← SHIFT.
- `in_ready` is combinational:
  - It is 1 in IDLE.
  - It is 1 in SHIFT only when `out_last && out_en` (back-to-back accept).
  - It is forced to 0 while `rst` is high.
- In SHIFT:
  - `out_valid` = 1.
  - `out_bit` = `sreg[0]` for data bits.
  - `out_first` = (`cnt` == 0).
  - `out_last` = (`cnt` == FRAME-1).
- An edge in SHIFT with `out_en`=1:
  - `sreg` shifts right with 0 filled at the MSB.
  - `cnt` increments.
- An edge in SHIFT with `out_en`=0 holds all state and outputs unchanged.
- Last bit consumed (`out_last && out_en`):
  - If `in_valid` is high, the new word is accepted at the same edge. State stays SHIFT and `cnt` ← 0, so there is no idle bubble.
  - Otherwise state ← IDLE.
- In IDLE:
  - `out_valid`, `out_first`, `out_last`, `busy` = 0.
  - `out_bit` = 0.
  - `out_en` is ignored.
- `in_data` is sampled only at the accept edge. Later changes to `in_data` do not affect the frame in flight.
- `cnt` never exceeds FRAME-1 in SHIFT, so it never wraps mid-frame.

## Timing
- Reset (`rst`=1 at an edge):
  - State ← IDLE; `sreg`, `cnt` ← 0.
  - All outputs 0 in the following cycle, except `in_ready`, which is 1 once `rst` deasserts.
- Reset mid-frame aborts the frame immediately. The partial frame is never resumed, and no `out_last` is produced.
- Reset has priority over a simultaneous accept and over `out_en`.
- Latency: accept at edge N → bit 0 valid on `out_bit` in cycle N+1.
- With `out_en` held at 1:
  - A frame occupies exactly FRAME consecutive cycles.
  - Back-to-back words stream at 1 bit/cycle with no gap.
- `out_first` and `out_last` are mutually exclusive because WIDTH ≥ 2.

## Configuration
- Macro `WORD_SERIALIZER_PARITY_EN`.
- Defined:
  - FRAME = WIDTH+1.
  - After the WIDTH data bits, one extra bit is emitted: the even-parity bit, the XOR of all bits of the accepted word.
  - Parity is computed and registered at the accept edge.
  - `out_last` is asserted on the parity bit, not on bit WIDTH-1.
- Undefined:
  - FRAME = WIDTH; no parity logic or register is present.
  - `out_last` is asserted on bit WIDTH-1.

## Test plan
- Reset then single word: `rst` for 2 cycles, then accept 8'hA5 with `out_en`=1.
  - `out_bit` sequence is 1,0,1,0,0,1,0,1.
  - `out_first` is asserted in cycle 1 and `out_last` in cycle 8.
  - Next cycle: IDLE, `in_ready`=1.
  - With parity: a 9th bit = 0, carrying `out_last`.
- Stall: accept 8'h0F and toggle `out_en` 1,0,0,1,…
  - Bits hold across the 0 cycles.
  - Only 8 (parity: 9) bits are consumed, giving 1,1,1,1,0,0,0,0.
  - `out_last` stays high until consumed.
- Back-to-back: keep `in_valid` high with 8'h01 then 8'h80 and `out_en`=1.
  - 16 contiguous valid cycles.
  - `in_ready` pulses only in the last-bit cycle.
  - `out_first` is asserted at cycles 1 and 9.
- Input stability: after accepting 8'h3C, change `in_data` to 8'hFF mid-frame.
  - The emitted bits still reflect 8'h3C.
  - `in_ready`=0 until the last bit.
- Reset mid-frame: accept 8'hFF, assert `rst` after 3 bits.
  - Next cycle `out_valid`=0 and no `out_last` is seen.
  - A new accept of 8'h02 then emits 0,1,0,0,0,0,0,0.
- Idle `out_en`: in IDLE, pulse `out_en` with `in_valid`=0 for 5 cycles.
  - `out_valid` stays 0 and there are no state changes.
